// File: rtl/mac_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_acc_pkg
// Brief    : Shared types and constants for the per-lane MAC accumulator
//            controller (state encoding, default widths, saturation limits).
// Revision : 1.0
// ============================================================================
package mac_acc_pkg;

    localparam int C_DEF_BIT_WIDTH = 32;
    localparam int C_DEF_ADDR_BITS = 6;
    localparam int C_DEF_CNT_BITS  = 16;

    // Saturation limits applied by the multiply unit; this block stores its results verbatim.
    localparam logic [C_DEF_BIT_WIDTH-1:0] C_SAT_MAX = {1'b0, {(C_DEF_BIT_WIDTH-1){1'b1}}};
    localparam logic [C_DEF_BIT_WIDTH-1:0] C_SAT_MIN = {1'b1, {(C_DEF_BIT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage : mac_acc_pkg
`default_nettype wire

// File: rtl/mac_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac_acc_ctrl
// Brief    : Holds the running partial sum for one SIMD multiply lane, counts
//            products down and presents the final sum on a valid/ready port.
//            Optional ReLU on the output when MAC_ACC_RELU_EN is defined.
// Revision : 1.0
// ============================================================================
module mac_acc_ctrl
    import mac_acc_pkg::*;
#(
    parameter int BIT_WIDTH = C_DEF_BIT_WIDTH,
    parameter int ADDR_BITS = C_DEF_ADDR_BITS,
    parameter int CNT_BITS  = C_DEF_CNT_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_BITS-1:0]  cfg_count,
    input  logic [BIT_WIDTH-1:0] cfg_init,
    input  logic [ADDR_BITS-1:0] cfg_dest_addr,
`ifdef MAC_ACC_RELU_EN
    input  logic                 relu_en,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic [BIT_WIDTH-1:0] data_acc,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic                 done
);

    state_t               r_state;
    state_t               w_next;
    logic [BIT_WIDTH-1:0] r_acc;
    logic [CNT_BITS-1:0]  r_remaining;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_done;
    logic                 r_relu;
    logic                 w_load;
    logic                 w_accept;
    logic                 w_relu_cfg;

`ifdef MAC_ACC_RELU_EN
    assign w_relu_cfg = relu_en;
`else
    assign w_relu_cfg = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A new run is accepted from IDLE, or in the same cycle as the HOLD handshake.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = (cfg_count == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (r_remaining == CNT_BITS'(1)) begin
                        w_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        w_load = 1'b1;
                        w_next = (cfg_count == '0) ? HOLD : ACCUM;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_remaining <= '0;
            r_addr      <= '0;
            r_relu      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == HOLD) && out_ready;
            if (w_load) begin
                r_acc       <= cfg_init;
                r_remaining <= cfg_count;
                r_addr      <= cfg_dest_addr;
                r_relu      <= w_relu_cfg;
            end else if (w_accept) begin
                r_acc       <= in_data;
                r_remaining <= r_remaining - CNT_BITS'(1);
            end
        end
    end

    always_comb begin
        in_ready  = (r_state == ACCUM);
        out_valid = (r_state == HOLD);
        busy      = (r_state == ACCUM) || (r_state == HOLD);
        data_acc  = r_acc;
        out_addr  = r_addr;
        done      = r_done;
        out_data  = (r_relu && r_acc[BIT_WIDTH-1]) ? '0 : r_acc;
    end

endmodule : mac_acc_ctrl
`default_nettype wire

// File: tb/tb_mac_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_acc_ctrl
// Brief    : Self-checking bench for mac_acc_ctrl with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_mac_acc_ctrl;

`ifdef MAC_ACC_RELU_EN
    localparam bit C_RELU_BUILD = 1'b1;
`else
    localparam bit C_RELU_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] cfg_count;
    logic [31:0] cfg_init;
    logic [5:0]  cfg_dest_addr;
    logic        relu_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] data_acc;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_addr;
    logic        done;

    int vectors = 0;
    int fails   = 0;

    logic [31:0] dq[$];
    bit          vq[$];

    mac_acc_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_count     (cfg_count),
        .cfg_init      (cfg_init),
        .cfg_dest_addr (cfg_dest_addr),
`ifdef MAC_ACC_RELU_EN
        .relu_en       (relu_en),
`endif
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .data_acc      (data_acc),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_addr      (out_addr),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] relu_of(input logic [31:0] v, input bit r);
        return (C_RELU_BUILD && r && v[31]) ? 32'h0 : v;
    endfunction

    task automatic do_start(input logic [15:0] cnt, input logic [31:0] init,
                            input logic [5:0] addr, input bit r);
        start         = 1'b1;
        cfg_count     = cnt;
        cfg_init      = init;
        cfg_dest_addr = addr;
        relu_en       = r;
        step();
        start     = 1'b0;
        cfg_count = 16'($urandom);
    endtask

    // Feeds cnt products; data_acc must always show the last accepted value.
    task automatic accum_loop(input int cnt, input logic [31:0] init, input int gap_pct,
                              output logic [31:0] fin);
        logic [31:0] acc;
        int          n;
        bit          first;
        bit          v;
        logic [31:0] d;
        acc   = init;
        n     = 0;
        first = 1'b1;
        while (n < cnt) begin
            chk("accum_data_acc", data_acc, acc);
            chk("accum_in_ready", 32'(in_ready), 32'd1);
            chk("accum_out_valid", 32'(out_valid), 32'd0);
            chk("accum_busy", 32'(busy), 32'd1);
            if (!first) chk("accum_done", 32'(done), 32'd0);
            first = 1'b0;
            v = (vq.size() > 0) ? vq.pop_front() : ($urandom_range(0, 99) >= 32'(gap_pct));
            d = (dq.size() > 0) ? dq.pop_front() : $urandom;
            in_valid = v;
            in_data  = d;
            start    = 1'($urandom_range(0, 1));
            step();
            if (v) begin
                acc = d;
                n++;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        fin      = acc;
    endtask

    task automatic hold_phase(input logic [31:0] acc, input logic [5:0] addr, input bit r,
                              input int waitc, input bit b2b, input logic [15:0] ncnt,
                              input logic [31:0] ninit, input logic [5:0] naddr, input bit nr);
        logic [31:0] expo;
        expo = relu_of(acc, r);
        for (int i = 0; i <= waitc; i++) begin
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_out_data", out_data, expo);
            chk("hold_out_addr", 32'(out_addr), 32'(addr));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_data_acc", data_acc, acc);
            if (i > 0) chk("hold_done", 32'(done), 32'd0);
            if (i < waitc) begin
                out_ready     = 1'b0;
                start         = 1'($urandom_range(0, 1));
                cfg_count     = 16'($urandom);
                cfg_init      = $urandom;
                cfg_dest_addr = 6'($urandom);
                in_valid      = 1'($urandom_range(0, 1));
                in_data       = $urandom;
                step();
            end
        end
        out_ready     = 1'b1;
        in_valid      = 1'b0;
        start         = b2b;
        cfg_count     = ncnt;
        cfg_init      = ninit;
        cfg_dest_addr = naddr;
        relu_en       = nr;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("hs_done", 32'(done), 32'd1);
        if (b2b) begin
            chk("b2b_busy", 32'(busy), 32'd1);
            chk("b2b_data_acc", data_acc, ninit);
            chk("b2b_in_ready", 32'(in_ready), 32'(ncnt != 16'd0));
            chk("b2b_out_valid", 32'(out_valid), 32'(ncnt == 16'd0));
        end else begin
            chk("hs_busy", 32'(busy), 32'd0);
            chk("hs_out_valid", 32'(out_valid), 32'd0);
            chk("hs_in_ready", 32'(in_ready), 32'd0);
            step();
            chk("post_done", 32'(done), 32'd0);
            chk("post_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_acc"}, data_acc, 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_out_addr"}, 32'(out_addr), 32'd0);
    endtask

    initial begin
        logic [31:0] fin;
        logic [15:0] ccnt, ncnt;
        logic [31:0] cinit, ninit;
        logic [5:0]  caddr, naddr;
        bit          crelu, nrelu, b2b;

        reset = 1'b1; start = 1'b0; cfg_count = '0; cfg_init = '0; cfg_dest_addr = '0;
        relu_en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_all_zero("reset");

        // in_valid while idle is not consumed
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        step();
        in_valid = 1'b0;
        chk_all_zero("idle_invalid");

        // Directed run: init 10, three products
        dq = '{32'd20, 32'd35, 32'd41};
        vq = '{1'b1, 1'b1, 1'b1};
        do_start(16'd3, 32'd10, 6'd5, 1'b0);
        accum_loop(3, 32'd10, 0, fin);
        hold_phase(fin, 6'd5, 1'b0, 0, 1'b0, 16'd0, 32'd0, 6'd0, 1'b0);

        // Count zero goes straight to HOLD with the bias
        do_start(16'd0, -32'sd7, 6'd9, 1'b0);
        hold_phase(-32'sd7, 6'd9, 1'b0, 2, 1'b0, 16'd0, 32'd0, 6'd0, 1'b0);

        // Long stall in HOLD then back-to-back start with count 2, gapped valid
        do_start(16'd1, 32'd77, 6'd3, 1'b0);
        accum_loop(1, 32'd77, 0, fin);
        hold_phase(fin, 6'd3, 1'b0, 5, 1'b1, 16'd2, 32'd100, 6'd7, 1'b0);
        vq = '{1'b1, 1'b0, 1'b0, 1'b1};
        accum_loop(2, 32'd100, 0, fin);
        hold_phase(fin, 6'd7, 1'b0, 1, 1'b0, 16'd0, 32'd0, 6'd0, 1'b0);

        // Reset mid-ACCUM with four products outstanding
        do_start(16'd6, 32'd123, 6'd4, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd1;
        step();
        in_data  = 32'd2;
        step();
        in_valid = 1'b0;
        chk("pre_reset_acc", data_acc, 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_zero("midrun_reset");
        do_start(16'd2, 32'd55, 6'd11, 1'b0);
        accum_loop(2, 32'd55, 20, fin);
        hold_phase(fin, 6'd11, 1'b0, 0, 1'b0, 16'd0, 32'd0, 6'd0, 1'b0);

        // Most-negative final value with and without ReLU
        dq = '{32'h8000_0000};
        vq = '{1'b1};
        do_start(16'd1, 32'd0, 6'd2, 1'b1);
        accum_loop(1, 32'd0, 0, fin);
        hold_phase(fin, 6'd2, 1'b1, 0, 1'b0, 16'd0, 32'd0, 6'd0, 1'b0);
        dq = '{32'h8000_0000};
        vq = '{1'b1};
        do_start(16'd1, 32'd0, 6'd2, 1'b0);
        accum_loop(1, 32'd0, 0, fin);
        hold_phase(fin, 6'd2, 1'b0, 0, 1'b0, 16'd0, 32'd0, 6'd0, 1'b0);
        dq = '{32'h0000_0042};
        vq = '{1'b1};
        do_start(16'd1, 32'hFFFF_FFF0, 6'd1, 1'b1);
        accum_loop(1, 32'hFFFF_FFF0, 0, fin);
        hold_phase(fin, 6'd1, 1'b1, 0, 1'b0, 16'd0, 32'd0, 6'd0, 1'b0);

        // Randomized chained transactions
        ccnt  = 16'($urandom_range(0, 6));
        cinit = $urandom;
        caddr = 6'($urandom);
        crelu = 1'($urandom_range(0, 1));
        do_start(ccnt, cinit, caddr, crelu);
        for (int t = 0; t < 25; t++) begin
            accum_loop(int'(ccnt), cinit, 30, fin);
            ncnt  = 16'($urandom_range(0, 6));
            ninit = $urandom;
            naddr = 6'($urandom);
            nrelu = 1'($urandom_range(0, 1));
            b2b   = (t < 24) && ($urandom_range(0, 1) == 1);
            hold_phase(fin, caddr, crelu, $urandom_range(0, 3), b2b, ncnt, ninit, naddr, nrelu);
            if (!b2b && t < 24) do_start(ncnt, ninit, naddr, nrelu);
            ccnt = ncnt; cinit = ninit; caddr = naddr; crelu = nrelu;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule : tb_mac_acc_ctrl
`default_nettype wire

// File: doc/mac_acc_ctrl.md
Name: mac_acc_ctrl

Overview:
- Sequencing and accumulator-holding stage placed directly downstream of the SIMD multiply unit, one instance per lane.
- Holds the running partial sum and drives it back as the multiplier's accumulator operand.
- Captures each saturated multiply-accumulate result and counts products down.
- Presents the finished sum with its destination address on a valid/ready output port.

Parameters:
- BIT_WIDTH, 32, datapath width; equals the multiply unit's BIT_WIDTH.
- ADDR_BITS, 6, destination register address width.
- CNT_BITS, 16, product-count width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- start  in  1  begin a new accumulation (configuration sampled when accepted).
- cfg_count  in  CNT_BITS  number of products to accumulate.
- cfg_init  in  BIT_WIDTH  signed initial accumulator value (bias).
- cfg_dest_addr  in  ADDR_BITS  destination address for the result.
- in_valid  in  1  multiply unit result valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  BIT_WIDTH  signed, saturated acc result from the multiply unit.
- data_acc  out  BIT_WIDTH  current accumulator, fed to the multiply unit's accumulator input.
- busy  out  1  accumulation in progress or result pending.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  BIT_WIDTH  signed final result.
- out_addr  out  ADDR_BITS  destination address of the result.
- done  out  1  one-cycle pulse, registered, in the cycle after the output handshake.

Behaviour:
- Reset: synchronous, active-high; required behaviour is the same idle or mid-run.
  - State goes to IDLE.
  - acc_reg, remaining and addr_reg clear to 0.
  - All outputs read 0: data_acc=0, in_ready=0, out_valid=0, busy=0, done=0.
  - Any partial accumulation is discarded.
- States: IDLE, ACCUM, HOLD. busy=1 in ACCUM and HOLD.
- IDLE, on start=1:
  - acc_reg<=cfg_init, remaining<=cfg_count, addr_reg<=cfg_dest_addr.
  - Next state is ACCUM, or HOLD if cfg_count==0.
- ACCUM:
  - in_ready=1.
  - On in_valid: acc_reg<=in_data and remaining<=remaining-1.
  - If remaining==1 on that accept, next state is HOLD.
  - With no in_valid, all state is held.
  - start is ignored.
- HOLD:
  - out_valid=1, out_data=acc_reg, out_addr=addr_reg; both are stable until the handshake.
  - On out_ready, next state is IDLE and done=1 in the following cycle.
  - Back-to-back: start=1 in the same cycle as the handshake is accepted; next state is ACCUM (or HOLD for count 0) with the new configuration. done still pulses.
  - start while in HOLD without out_ready is ignored, not queued.
- data_acc = acc_reg at all times. The multiply path is combinational, so in_data reflects the current data_acc in the same cycle.
- Latency:
  - N products take N accepting cycles.
  - out_valid rises in the cycle after the last accept.
  - Minimum start-to-out_valid is N+1 cycles.
- Arithmetic: none in this block. Saturation is done upstream, and in_data is stored verbatim.
- cfg_count wrap: the maximum value 2^CNT_BITS-1 is legal. remaining never underflows because ACCUM exits at 1.
- in_valid while in IDLE or HOLD: in_ready=0 and the data is not consumed.

Optional Feature:
- Macro MAC_ACC_RELU_EN.
- Defined:
  - Adds an input relu_en (1 bit), sampled at start.
  - When relu_en was 1, out_data = acc_reg[BIT_WIDTH-1] ? 0 : acc_reg.
  - data_acc is unaffected.
- Undefined: no relu_en port; out_data = acc_reg.

Decomposition:
- Package mac_acc_pkg holds:
  - the state typedef (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2);
  - default width localparams;
  - the signed max/min saturation constants shared with the multiply unit.
- No sub-module; a single always_ff FSM plus combinational output decode.

Test Plan:
- start, cfg_init=10, cfg_count=3, addr=5; in_data 20, 35, 41 (in_valid every cycle) -> data_acc steps 10, 20, 35, 41; out_valid in cycle 4 with out_data=41, out_addr=5; done pulses the cycle after out_ready.
- cfg_count=0, cfg_init=-7 -> HOLD next cycle; out_data=-7; in_ready stays 0.
- out_ready low for 5 cycles in HOLD -> out_valid, out_data and out_addr hold steady; start pulses are ignored; on out_ready=1 with start=1 and new count=2 -> ACCUM entered directly, done pulses.
- in_valid toggled 1,0,0,1 with count=2 -> exactly 2 accepts, remaining holds during gaps, out_valid after the 2nd accept only.
- reset asserted mid-ACCUM (remaining=4) -> next cycle every output is 0 and state is IDLE; a subsequent start runs cleanly.
- With MAC_ACC_RELU_EN, relu_en=1 and final acc 0x80000000 -> out_data=0. With relu_en=0 -> out_data=0x80000000.
